// File: rtl/procesador_fifo_mm_to_st.sv
`default_nettype none
// ============================================================================
// Module   : procesador_fifo_mm_to_st
// Brief    : Avalon-MM write FIFO played out on an Avalon-ST source, with
//            fill-level status read and software flush.
// Revision : 1.0 - initial release
// ============================================================================
module procesador_fifo_mm_to_st #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              wrclock,
    input  logic              reset,
    input  logic              avalonmm_slave_address,
    input  logic              avalonmm_slave_write,
    input  logic [DATA_W-1:0] avalonmm_slave_writedata,
    input  logic              avalonmm_slave_read,
    output logic [31:0]       avalonmm_slave_readdata,
    output logic              avalonmm_slave_waitrequest,
    output logic [DATA_W-1:0] avalonst_source_data,
    output logic              avalonst_source_valid,
    input  logic              avalonst_source_ready
);

    localparam logic [ADDR_W:0] C_FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              full_w;
    logic              empty_w;
    logic              push_w;
    logic              pop_w;
    logic              flush_w;
    logic              load_slot_w;
    logic              ram_has_w;
    logic              ram_we_w;
    logic [ADDR_W:0]   ram_cnt_w;
    logic [15:0]       level16_w;
    logic [31:0]       status_w;

    assign full_w    = (level_q == C_FULL_LEVEL);
    assign empty_w   = (level_q == '0);
    assign level16_w = 16'(level_q);
    assign status_w  = {full_w, empty_w, 14'b0, level16_w};

    // Stall depends only on the registered level, so a push at full waits
    // even when a pop frees a slot in the same cycle.
    assign avalonmm_slave_waitrequest = reset |
        (avalonmm_slave_write & ~avalonmm_slave_address & full_w);

    assign push_w  = avalonmm_slave_write & ~avalonmm_slave_address &
                     ~avalonmm_slave_waitrequest;
    assign pop_w   = out_valid_q & avalonst_source_ready;
    assign flush_w = avalonmm_slave_write & avalonmm_slave_address &
                     avalonmm_slave_writedata[0];

    // Words held in RAM exclude the one sitting in the output register.
    assign ram_cnt_w   = level_q - (ADDR_W+1)'(out_valid_q);
    assign ram_has_w   = (ram_cnt_w != '0);
    assign load_slot_w = ~out_valid_q | pop_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ram_we_w    = 1'b0;
        readdata_d  = readdata_q;

        if (avalonmm_slave_read) begin
            readdata_d = avalonmm_slave_address ? 32'd0 : status_w;
        end

        if (flush_w) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            level_d = level_q + (ADDR_W+1)'(push_w) - (ADDR_W+1)'(pop_w);
            if (load_slot_w && ram_has_w) begin
                out_data_d  = ram_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + 1'b1;
                ram_we_w    = push_w;
            end else if (load_slot_w) begin
                // RAM empty: same-cycle write data bypasses straight out.
                out_valid_d = push_w;
                if (push_w) begin
                    out_data_d = avalonmm_slave_writedata;
                end
            end else begin
                ram_we_w = push_w;
            end
            if (ram_we_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wrclock) begin
        if (ram_we_w) begin
            ram_q[wr_ptr_q] <= avalonmm_slave_writedata;
        end
    end

    always_ff @(posedge wrclock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            readdata_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            readdata_q  <= readdata_d;
        end
    end

    assign avalonmm_slave_readdata = readdata_q;
    assign avalonst_source_data    = out_data_q;
    assign avalonst_source_valid   = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_procesador_fifo_mm_to_st.sv
`default_nettype none
// Scoreboard bench: a queue model tracks held words; a negedge monitor
// compares stream, stall and status outputs against it every cycle.
module tb_procesador_fifo_mm_to_st;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              reset;
    logic              address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [31:0]       readdata;
    logic              waitreq;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              ready;

    procesador_fifo_mm_to_st #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .wrclock                    (clk),
        .reset                      (reset),
        .avalonmm_slave_address     (address),
        .avalonmm_slave_write       (write),
        .avalonmm_slave_writedata   (writedata),
        .avalonmm_slave_read        (read),
        .avalonmm_slave_readdata    (readdata),
        .avalonmm_slave_waitrequest (waitreq),
        .avalonst_source_data       (st_data),
        .avalonst_source_valid      (st_valid),
        .avalonst_source_ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    bit          rand_ready = 1'b0;
    logic [31:0] model[$];
    logic [31:0] exp_rd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare against the model state as of the last
    // edge, then apply this cycle's accepted transactions to the model.
    always @(negedge clk) begin
        int sz;
        if (mon_en) begin
            sz = model.size();
            chk("waitrequest", 32'(waitreq),
                32'(reset | (write & ~address & (sz == DEPTH))));
            chk("valid", 32'(st_valid), 32'(sz > 0));
            if (sz > 0) chk("stream_data", st_data, model[0]);
            chk("readdata", readdata, exp_rd);
            if (reset) begin
                model.delete();
                exp_rd = 32'd0;
            end else begin
                if (read)
                    exp_rd = address ? 32'd0 :
                             {(sz == DEPTH), (sz == 0), 14'b0, 16'(sz)};
                if (write && address && writedata[0]) begin
                    model.delete();
                end else begin
                    if (sz > 0 && ready) void'(model.pop_front());
                    if (write && !address && sz < DEPTH) model.push_back(writedata);
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) ready = 1'($urandom);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        address = 1'b0; writedata = d; write = 1'b1; read = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = !waitreq;
            step();
        end
        write = 1'b0;
        chk("write_accepted", 32'(ok), 32'd1);
    endtask

    task automatic status_read(input logic [31:0] exp);
        address = 1'b0; read = 1'b1;
        step();
        read = 1'b0;
        @(negedge clk);
        chk("status_word", readdata, exp);
        step();
    endtask

    task automatic flush();
        address = 1'b1; writedata = 32'h1; write = 1'b1;
        step();
        write = 1'b0; address = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 3000 && model.size() > 0; i++) step();
        chk("drain_complete", model.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = 1'b0; write = 1'b0; writedata = '0;
        read = 1'b0; ready = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(st_valid), 32'd0);
        chk("reset_data", st_data, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        step();

        // Three words with sink ready, then empty status.
        ready = 1'b1;
        mm_write(32'h11); mm_write(32'h22); mm_write(32'h33);
        repeat (3) step();
        status_read(32'h4000_0000);

        // Fill to capacity, stall the 129th word until one pop.
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mm_write(32'(i));
        status_read(32'h8000_0080);
        fork
            mm_write(32'h0000_0200);
            begin
                repeat (4) step();
                ready = 1'b1;
                step();
                ready = 1'b0;
            end
        join
        ready = 1'b1;
        wait_empty();

        // Level 64 with simultaneous push and pop.
        ready = 1'b0;
        for (int i = 0; i < 64; i++) mm_write($urandom);
        ready = 1'b1;
        for (int i = 0; i < 500; i++) mm_write($urandom);
        ready = 1'b0;
        status_read(32'h0000_0040);
        ready = 1'b1;
        wait_empty();

        // Flush at level 10 while ready toggles.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) mm_write(32'hA000_0000 + 32'(i));
        rand_ready = 1'b1;
        repeat (4) step();
        rand_ready = 1'b0;
        ready = 1'b1;
        flush();
        @(negedge clk);
        chk("flush_valid", 32'(st_valid), 32'd0);
        step();
        status_read(32'h4000_0000);
        mm_write(32'hABCD_0001);
        wait_empty();

        // Reset mid-stream at level 50.
        ready = 1'b0;
        for (int i = 0; i < 50; i++) mm_write(32'hB000_0000 + 32'(i));
        status_read(32'h0000_0032);
        ready = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_valid", 32'(st_valid), 32'd0);
        chk("midreset_readdata", readdata, 32'd0);
        step();
        status_read(32'h4000_0000);
        mm_write(32'hDEAD_BEEF);
        wait_empty();

        // Pointer wrap with random backpressure and write gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            mm_write($urandom);
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        wait_empty();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
